branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor for the IF stage of the pipelined RV32I core.
- Combines a direct-mapped branch target buffer (BTB) with a 2-bit saturating-counter history table.
- Each cycle it gives the fetch PC mux a predicted next PC. The EX stage trains it from resolved branches and jumps.
- It also exports branch and mispredict statistics counters, which the branch-prediction scoreboard cross-checks.

Parameters:
- INDEX_W, 6, BTB index width; the table has 2**INDEX_W entries.
- TAG_W, 32-INDEX_W-2, tag width (derived; not overridden).
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_if_pc  in  32  fetch-stage PC.
- o_pred_taken  out  1  prediction for i_if_pc: taken.
- o_pred_target  out  32  predicted next PC.
- i_upd_vld  in  1  EX resolved a branch/jal/jalr this cycle.
- i_upd_pc  in  32  PC of the resolved instruction.
- i_upd_taken  in  1  actual outcome.
- i_upd_target  in  32  actual target (valid when taken).
- i_upd_mispred  in  1  EX detected a misprediction for this instruction.
- o_br_cnt  out  CNT_W  number of resolved branches.
- o_mispred_cnt  out  CNT_W  number of mispredictions.

Behaviour:
- Address split:
  - PC[1:0] ignored.
  - idx = PC[INDEX_W+1:2].
  - tag = PC[31:INDEX_W+2].
- Entry state: valid (1b), tag (TAG_W), target (32), cnt (2b).
- Prediction (combinational, zero latency from i_if_pc):
  - hit = valid[idx] && tag match.
  - o_pred_taken = hit && cnt[1].
  - o_pred_target = o_pred_taken ? target : i_if_pc+4. The +4 wraps modulo 2^32.
- Update on the rising edge when i_upd_vld=1, using the update index:
  - Hit, taken: cnt saturating-increments (max 2'b11); target is overwritten with i_upd_target.
  - Hit, not taken: cnt saturating-decrements (min 2'b00); target is unchanged.
  - Miss, taken: allocate or replace the entry. valid=1, tag=update tag, target=i_upd_target, cnt=2'b10 (weak taken).
  - Miss, not taken: no allocation; the entry is untouched.
- Read/write collision (i_if_pc and i_upd_pc map to the same idx in one cycle):
  - The prediction uses the pre-update contents; there is no bypass.
  - The new contents are visible from the next cycle.
- Statistics counters:
  - o_br_cnt increments by 1 on each cycle with i_upd_vld.
  - o_mispred_cnt increments on i_upd_vld && i_upd_mispred.
  - Both saturate at all-ones and never wrap.
  - i_upd_mispred without i_upd_vld is ignored.
- Reset (i_rst=1 on a clock edge):
  - All valid bits are cleared and all cnt set to 2'b01 (weak not-taken). Tags and targets are don't-care.
  - Both statistics counters are cleared to 0.
  - Reset takes priority over any simultaneous update; that update is dropped.
  - Reset asserted mid-operation behaves identically to reset at power-up.
- Output values during and after reset:
  - o_pred_taken=0.
  - o_pred_target=i_if_pc+4.
  - Statistics outputs are 0 from the first edge after reset assertion.
- Storage is flops. It must be reset-clearable in one cycle, so no SRAM macro is used.

Decomposition:
- singlecycle_pkg gains:
  - bht_cnt_e: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11.
  - btb_entry_t: a packed struct {valid, tag, target, cnt}, parameterised via the INDEX_W localparam.
  - A sat_update function (cnt, taken) returning the next count.
- One sub-module, branch_pred_table, is natural. It holds the entry array and provides:
  - A combinational read port.
  - A synchronous write port with reset clearing.
- The top level contains tag compare, target mux, update decision logic and the statistics counters.

Test Plan:
1. Reset, then i_if_pc=0x0000_0100 with no updates -> o_pred_taken=0, o_pred_target=0x0000_0104, o_br_cnt=0, o_mispred_cnt=0.
2. One update: pc=0x100, taken=1, target=0x200, mispred=1. Then i_if_pc=0x100 -> o_pred_taken=1, o_pred_target=0x200, o_br_cnt=1, o_mispred_cnt=1.
3. Train pc=0x100 taken three more times, then not-taken once -> cnt path 10→11→11→11→10; prediction stays taken with target 0x200. Two further not-taken updates -> cnt=00 and o_pred_taken=0.
4. Aliasing with INDEX_W=6: entry at 0x100 (taken, target 0x200), then update pc=0x200 (same idx, different tag), taken, target 0x300 -> 0x100 misses (pred 0x104); 0x200 predicts 0x300 with cnt=10.
5. Same-cycle collision: i_if_pc=0x100 while updating 0x100 taken, target 0x400 -> that cycle shows the old prediction; the next cycle shows 0x400.
6. Statistics saturation and reset priority:
   - Force o_mispred_cnt to 0xFFFF_FFFF, then apply a mispredicted update -> stays 0xFFFF_FFFF.
   - Assert i_rst together with i_upd_vld (taken, pc 0x100) -> after the edge 0x100 misses and both counters read 0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the IF-stage branch predictor: BTB entry layout and the
// 2-bit saturating history counter.
package branch_predictor_pkg;

  localparam int BTB_INDEX_W = 6;
  localparam int BTB_TAG_W   = 32 - BTB_INDEX_W - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bht_cnt_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    bht_cnt_e             cnt;
  } btb_entry_t;

  function automatic bht_cnt_e sat_update(input bht_cnt_e cnt, input logic taken);
    bht_cnt_e next;
    case (cnt)
      STRONG_NT: next = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    next = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  next = taken ? STRONG_T : WEAK_T;
      default:   next = WEAK_NT;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/branch_pred_table.sv
// Flop-based BTB/BHT entry array: two combinational read ports (fetch and
// update lookup) and one synchronous write port with one-cycle reset clear.
module branch_pred_table
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] fetch_idx,
  output btb_entry_t         fetch_entry,
  input  logic [INDEX_W-1:0] upd_idx,
  output btb_entry_t         upd_entry,
  input  logic               wr_en,
  input  btb_entry_t         wr_entry
);

  localparam int DEPTH = 2 ** INDEX_W;

  btb_entry_t mem [DEPTH];

  assign fetch_entry = mem[fetch_idx];
  assign upd_entry   = mem[upd_idx];

  // Tags and targets are left alone on reset; a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].cnt   <= WEAK_NT;
      end
    end else if (wr_en) begin
      mem[upd_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit counters, trained
// from EX, with saturating branch/mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W = BTB_INDEX_W,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  input  logic             i_upd_vld,
  input  logic [31:0]      i_upd_pc,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_mispred,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  // The entry struct width comes from the package, so INDEX_W must track it.
  localparam int TAG_W = 32 - INDEX_W - 2;

  logic [INDEX_W-1:0] fetch_idx, upd_idx;
  logic [TAG_W-1:0]   fetch_tag, upd_tag;
  btb_entry_t         fetch_entry, upd_entry, wr_entry;
  logic               fetch_hit, upd_hit, wr_en;
  logic [1:0]         unused_upd_lsb;

  assign fetch_idx      = i_if_pc[INDEX_W+1:2];
  assign fetch_tag      = i_if_pc[31:INDEX_W+2];
  assign upd_idx        = i_upd_pc[INDEX_W+1:2];
  assign upd_tag        = i_upd_pc[31:INDEX_W+2];
  assign unused_upd_lsb = i_upd_pc[1:0];

  branch_pred_table #(.INDEX_W(INDEX_W)) u_table (
    .clk         (i_clk),
    .rst         (i_rst),
    .fetch_idx   (fetch_idx),
    .fetch_entry (fetch_entry),
    .upd_idx     (upd_idx),
    .upd_entry   (upd_entry),
    .wr_en       (wr_en),
    .wr_entry    (wr_entry)
  );

  assign fetch_hit = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  // No bypass: a same-index update in this cycle is seen only next cycle.
  always_comb begin
    o_pred_taken  = fetch_hit && ((fetch_entry.cnt == WEAK_T) || (fetch_entry.cnt == STRONG_T));
    o_pred_target = o_pred_taken ? fetch_entry.target : (i_if_pc + 32'd4);
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_entry;
    if (i_upd_vld && upd_hit) begin
      wr_en        = 1'b1;
      wr_entry.cnt = sat_update(upd_entry.cnt, i_upd_taken);
      if (i_upd_taken) begin
        wr_entry.target = i_upd_target;
      end else begin
        wr_entry.target = upd_entry.target;
      end
    end else if (i_upd_vld && i_upd_taken) begin
      wr_en           = 1'b1;
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = upd_tag;
      wr_entry.target = i_upd_target;
      wr_entry.cnt    = WEAK_T;
    end else begin
      wr_en = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else if (i_upd_vld) begin
      if (!(&o_br_cnt)) begin
        o_br_cnt <= o_br_cnt + CNT_W'(1);
      end
      if (i_upd_mispred && !(&o_mispred_cnt)) begin
        o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor; a second instance with 4-bit
// statistics counters shares all inputs so saturation is reachable.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        i_rst, i_upd_vld, i_upd_taken, i_upd_mispred;
  logic [31:0] i_if_pc, i_upd_pc, i_upd_target;
  logic        o_pred_taken, sat_taken;
  logic [31:0] o_pred_target, sat_target;
  logic [31:0] o_br_cnt, o_mispred_cnt;
  logic [3:0]  sat_br, sat_mis;

  always #5 clk = ~clk;

  branch_predictor dut (
    .i_clk(clk), .i_rst(i_rst), .i_if_pc(i_if_pc),
    .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
    .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_target(i_upd_target), .i_upd_mispred(i_upd_mispred),
    .o_br_cnt(o_br_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  branch_predictor #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst(i_rst), .i_if_pc(i_if_pc),
    .o_pred_taken(sat_taken), .o_pred_target(sat_target),
    .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .i_upd_target(i_upd_target), .i_upd_mispred(i_upd_mispred),
    .o_br_cnt(sat_br), .o_mispred_cnt(sat_mis)
  );

  typedef struct {
    logic        rst;
    logic [31:0] if_pc;
    logic        vld;
    logic [31:0] upd_pc;
    logic        tk;
    logic [31:0] tgt;
    logic        mis;
    logic        chk;
    logic        exp_taken;
    logic [31:0] exp_target;
  } row_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [31:0] br;
    logic [31:0] mis;
    logic [3:0]  sbr;
    logic [3:0]  smis;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned exp_br = 0, exp_mis = 0;
  int          n_cmp = 0, n_fail = 0;

  function automatic row_t mk(input logic rst, input logic [31:0] if_pc, input logic vld,
                              input logic [31:0] upd_pc, input logic tk, input logic [31:0] tgt,
                              input logic mis, input logic chk, input logic et,
                              input logic [31:0] etgt);
    row_t r;
    r.rst = rst; r.if_pc = if_pc; r.vld = vld; r.upd_pc = upd_pc; r.tk = tk;
    r.tgt = tgt; r.mis = mis; r.chk = chk; r.exp_taken = et; r.exp_target = etgt;
    return r;
  endfunction

  function automatic logic [3:0] sat4(input int unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  // Drive one cycle of stimulus and record what the outputs must show.
  task automatic apply(input row_t r);
    exp_t x;
    i_rst = r.rst; i_if_pc = r.if_pc; i_upd_vld = r.vld; i_upd_pc = r.upd_pc;
    i_upd_taken = r.tk; i_upd_target = r.tgt; i_upd_mispred = r.mis;
    if (r.chk) begin
      x.taken = r.exp_taken; x.target = r.exp_target;
      x.br = exp_br; x.mis = exp_mis; x.sbr = sat4(exp_br); x.smis = sat4(exp_mis);
      exp_q.push_back(x);
    end
  endtask

  task automatic advance(input row_t r);
    @(posedge clk);
    #1;
    if (r.rst) begin
      exp_br = 0; exp_mis = 0;
    end else if (r.vld) begin
      exp_br++;
      if (r.mis) exp_mis++;
    end
  endtask

  task automatic test_reset();
    row_t rows[$];
    rows.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h104));
    rows.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    rows.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h104));
    foreach (rows[k]) begin
      apply(rows[k]);
      if (rows[k].chk) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({o_pred_taken, o_pred_target, sat_taken, sat_target} !== {e.taken, e.target, e.taken, e.target}) begin
          n_fail++;
          $display("FAIL reset[%0d] pred: got %0b/%08h want %0b/%08h", k, o_pred_taken, o_pred_target, e.taken, e.target);
        end
        n_cmp++;
        if ({o_br_cnt, o_mispred_cnt, sat_br, sat_mis} !== {e.br, e.mis, e.sbr, e.smis}) begin
          n_fail++;
          $display("FAIL reset[%0d] stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k, o_br_cnt, o_mispred_cnt, sat_br, sat_mis, e.br, e.mis, e.sbr, e.smis);
        end
      end
      advance(rows[k]);
    end
  endtask

  task automatic test_train();
    row_t rows[$];
    // stray mispred without valid, then first allocation
    rows.push_back(mk(0, 32'h100, 0, 32'h100, 1, 32'h200, 1, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 1, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'hDE0, 0, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'hDE0, 0, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 0, 32'hDE0, 1, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h104));
    foreach (rows[k]) begin
      apply(rows[k]);
      if (rows[k].chk) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({o_pred_taken, o_pred_target} !== {e.taken, e.target}) begin
          n_fail++;
          $display("FAIL train[%0d] pred: got %0b/%08h want %0b/%08h", k, o_pred_taken, o_pred_target, e.taken, e.target);
        end
        n_cmp++;
        if ({o_br_cnt, o_mispred_cnt, sat_br, sat_mis} !== {e.br, e.mis, e.sbr, e.smis}) begin
          n_fail++;
          $display("FAIL train[%0d] stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k, o_br_cnt, o_mispred_cnt, sat_br, sat_mis, e.br, e.mis, e.sbr, e.smis);
        end
      end
      advance(rows[k]);
    end
  endtask

  task automatic test_alias_collision();
    row_t rows[$];
    rows.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h100, 1, 32'h200, 1, 32'h300, 1, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h200, 1, 32'h200, 0, 0, 0, 1, 1, 32'h300));
    rows.push_back(mk(0, 32'h200, 0, 0, 0, 0, 0, 1, 0, 32'h204));
    // same-index read and write in one cycle: old contents first
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h200, 0, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h100, 1, 32'h100, 1, 32'h400, 0, 1, 1, 32'h200));
    rows.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 1, 1, 32'h400));
    foreach (rows[k]) begin
      apply(rows[k]);
      if (rows[k].chk) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({o_pred_taken, o_pred_target} !== {e.taken, e.target}) begin
          n_fail++;
          $display("FAIL alias[%0d] pred: got %0b/%08h want %0b/%08h", k, o_pred_taken, o_pred_target, e.taken, e.target);
        end
        n_cmp++;
        if ({o_br_cnt, o_mispred_cnt, sat_br, sat_mis} !== {e.br, e.mis, e.sbr, e.smis}) begin
          n_fail++;
          $display("FAIL alias[%0d] stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k, o_br_cnt, o_mispred_cnt, sat_br, sat_mis, e.br, e.mis, e.sbr, e.smis);
        end
      end
      advance(rows[k]);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    for (int i = 0; i < 8; i++)
      rows.push_back(mk(0, 32'h1000 + 4 * i, 1, 32'h1000 + 4 * i, 1, 32'h2000 + 16 * i, 0, 1, 0, 32'h1004 + 4 * i));
    // not-taken miss on an occupied index must leave it alone
    rows.push_back(mk(0, 32'h3000, 1, 32'h3000, 0, 32'h5000, 0, 1, 0, 32'h3004));
    rows.push_back(mk(0, 32'h3000, 0, 0, 0, 0, 0, 1, 0, 32'h3004));
    for (int i = 0; i < 8; i++)
      rows.push_back(mk(0, 32'h1000 + 4 * i, 0, 0, 0, 0, 0, 1, 1, 32'h2000 + 16 * i));
    rows.push_back(mk(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    foreach (rows[k]) begin
      apply(rows[k]);
      if (rows[k].chk) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({o_pred_taken, o_pred_target} !== {e.taken, e.target}) begin
          n_fail++;
          $display("FAIL b2b[%0d] pred: got %0b/%08h want %0b/%08h", k, o_pred_taken, o_pred_target, e.taken, e.target);
        end
        n_cmp++;
        if ({o_br_cnt, o_mispred_cnt, sat_br, sat_mis} !== {e.br, e.mis, e.sbr, e.smis}) begin
          n_fail++;
          $display("FAIL b2b[%0d] stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k, o_br_cnt, o_mispred_cnt, sat_br, sat_mis, e.br, e.mis, e.sbr, e.smis);
        end
      end
      advance(rows[k]);
    end
  endtask

  task automatic test_saturation_reset_priority();
    row_t rows[$];
    for (int i = 0; i < 18; i++)
      rows.push_back(mk(0, 32'h1004, 1, 32'h1004, 1, 32'h2010, 1, 1, 1, 32'h2010));
    rows.push_back(mk(0, 32'h1004, 0, 0, 0, 0, 0, 1, 1, 32'h2010));
    // reset wins over a simultaneous taken update
    rows.push_back(mk(1, 32'h100, 1, 32'h100, 1, 32'h500, 1, 0, 0, 0));
    rows.push_back(mk(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h104));
    rows.push_back(mk(0, 32'h1004, 0, 0, 0, 0, 0, 1, 0, 32'h1008));
    foreach (rows[k]) begin
      apply(rows[k]);
      if (rows[k].chk) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({o_pred_taken, o_pred_target} !== {e.taken, e.target}) begin
          n_fail++;
          $display("FAIL satrst[%0d] pred: got %0b/%08h want %0b/%08h", k, o_pred_taken, o_pred_target, e.taken, e.target);
        end
        n_cmp++;
        if ({o_br_cnt, o_mispred_cnt, sat_br, sat_mis} !== {e.br, e.mis, e.sbr, e.smis}) begin
          n_fail++;
          $display("FAIL satrst[%0d] stats: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", k, o_br_cnt, o_mispred_cnt, sat_br, sat_mis, e.br, e.mis, e.sbr, e.smis);
        end
      end
      advance(rows[k]);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_if_pc = 32'h0; i_upd_vld = 1'b0; i_upd_pc = 32'h0;
    i_upd_taken = 1'b0; i_upd_target = 32'h0; i_upd_mispred = 1'b0;
    test_reset();
    test_train();
    test_alias_collision();
    test_back_to_back();
    test_saturation_reset_priority();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
